// File: rtl/cpu_pkg.sv
// Shared CPU types: opcodes, execute-stage states, widths.
// Used by the execute unit and by the decoder/sequencer.
package cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_MUL  = 3'b110,
    OP_MOVB = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    WB   = 2'b10
  } exec_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative 8x8 unsigned shift-add multiplier, 8 cycles.
// Ports: clk, reset, start (load operands), multiplicand,
// multiplier, done (last iteration cycle), product.
module shift_add_mul
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2:0]          iter;
  logic                active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      iter   <= '0;
      active <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, multiplicand};
      mplier <= multiplier;
      iter   <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      iter   <= iter + 3'd1;
      // Counter wrapping 7->0 ends the run.
      if (iter == 3'd7) begin
        active <= 1'b0;
      end
    end
  end

  // High during the final iteration; product is
  // complete after the edge that ends this cycle.
  assign done    = active && (iter == 3'd7);
  assign product = acc;

endmodule

// File: rtl/alu_execute_unit.sv
// Execute stage: 8-bit ALU plus iterative MUL, driving RF write port.
// Ports: clk, reset, start/op/aIn/bIn/destIn command, busy,
// result, writeAddress, writeEnable, zeroFlag, carryFlag.
module alu_execute_unit
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_W-1:0]     aIn,
  input  logic [DATA_W-1:0]     bIn,
  input  logic [REG_ADDR_W-1:0] destIn,
  output logic                  busy,
  output logic [DATA_W-1:0]     result,
  output logic [REG_ADDR_W-1:0] writeAddress,
  output logic                  writeEnable,
  output logic                  zeroFlag,
  output logic                  carryFlag
);

  exec_state_t           state;
  op_t                   opIn;
  op_t                   opReg;
  logic [REG_ADDR_W-1:0] destReg;
  logic [DATA_W-1:0]     workResult;
  logic                  workCarry;
  logic [DATA_W-1:0]     resultReg;
  logic                  zeroReg;
  logic                  carryReg;

  logic [DATA_W:0]       sum9;
  logic [DATA_W:0]       diff9;
  logic [DATA_W-1:0]     aluRes;
  logic                  aluCarry;
  logic [DATA_W-1:0]     wbResult;
  logic                  wbCarry;

  logic                  accept;
  logic                  mulStart;
  logic                  mulDone;
  logic [2*DATA_W-1:0]   product;

  assign opIn     = op_t'(op);
  assign accept   = (state == IDLE) && start;
  assign mulStart = accept && (opIn == OP_MUL);

  shift_add_mul uMul (
    .clk          (clk),
    .reset        (reset),
    .start        (mulStart),
    .multiplicand (aIn),
    .multiplier   (bIn),
    .done         (mulDone),
    .product      (product)
  );

  assign sum9  = {1'b0, aIn} + {1'b0, bIn};
  // Bit 8 of the 9-bit difference is the borrow (a < b).
  assign diff9 = {1'b0, aIn} - {1'b0, bIn};

  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    unique case (opIn)
      OP_ADD: begin
        aluRes   = sum9[DATA_W-1:0];
        aluCarry = sum9[DATA_W];
      end
      OP_SUB: begin
        aluRes   = diff9[DATA_W-1:0];
        aluCarry = diff9[DATA_W];
      end
      OP_AND:  aluRes = aIn & bIn;
      OP_OR:   aluRes = aIn | bIn;
      OP_XOR:  aluRes = aIn ^ bIn;
      OP_SHL: begin
        aluRes   = {aIn[DATA_W-2:0], 1'b0};
        aluCarry = aIn[DATA_W-1];
      end
      OP_MUL:  aluRes = '0;
      OP_MOVB: aluRes = bIn;
    endcase
  end

  // MUL results come straight from the multiplier.
  always_comb begin
    wbResult = workResult;
    wbCarry  = workCarry;
    if (opReg == OP_MUL) begin
      wbResult = product[DATA_W-1:0];
      wbCarry  = |product[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      opReg      <= OP_ADD;
      destReg    <= '0;
      workResult <= '0;
      workCarry  <= 1'b0;
      resultReg  <= '0;
      zeroReg    <= 1'b0;
      carryReg   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            opReg      <= opIn;
            destReg    <= destIn;
            workResult <= aluRes;
            workCarry  <= aluCarry;
            state      <= (opIn == OP_MUL) ? MUL : WB;
          end
        end
        MUL: begin
          if (mulDone) begin
            state <= WB;
          end
        end
        WB: begin
          resultReg <= wbResult;
          zeroReg   <= (wbResult == '0);
          carryReg  <= wbCarry;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back data is visible during WB, then held.
  assign result       = (state == WB) ? wbResult : resultReg;
  assign writeAddress = destReg;
  assign writeEnable  = (state == WB);
  assign busy         = (state != IDLE);
  assign zeroFlag     = zeroReg;
  assign carryFlag    = carryReg;

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed self-checking bench for alu_execute_unit.
// Table-driven ops plus contention, reset and back-to-back cases.
module tb_alu_execute_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] aIn;
  logic [7:0] bIn;
  logic [1:0] destIn;
  logic       busy;
  logic [7:0] result;
  logic [1:0] writeAddress;
  logic       writeEnable;
  logic       zeroFlag;
  logic       carryFlag;

  int checks;
  int errors;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] dest;
    logic [7:0] res;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs[12];

  alu_execute_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .aIn          (aIn),
    .bIn          (bIn),
    .destIn       (destIn),
    .busy         (busy),
    .result       (result),
    .writeAddress (writeAddress),
    .writeEnable  (writeEnable),
    .zeroFlag     (zeroFlag),
    .carryFlag    (carryFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [1:0] d);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    aIn    = a;
    bIn    = b;
    destIn = d;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic runOp(input vec_t v, input int idx);
    int lat;
    int weN;
    lat = (v.op == 3'b110) ? 9 : 1;
    weN = 0;
    issue(v.op, v.a, v.b, v.dest);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d_busy_c%0d", idx, c),
          16'(busy), 16'(c <= lat));
      chk($sformatf("v%0d_we_c%0d", idx, c),
          16'(writeEnable), 16'(c == lat));
      if (writeEnable) weN++;
      if (c == lat) begin
        chk($sformatf("v%0d_result", idx),
            16'(result), 16'(v.res));
        chk($sformatf("v%0d_waddr", idx),
            16'(writeAddress), 16'(v.dest));
      end
      if (c == lat + 1) begin
        chk($sformatf("v%0d_hold", idx),
            16'(result), 16'(v.res));
        chk($sformatf("v%0d_carry", idx),
            16'(carryFlag), 16'(v.c));
        chk($sformatf("v%0d_zero", idx),
            16'(zeroFlag), 16'(v.z));
      end
    end
    chk($sformatf("v%0d_weCount", idx), 16'(weN), 16'd1);
  endtask

  initial begin
    int weN;
    int weAt;
    int we1;
    int we2;
    vec_t v;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'b000;
    aIn    = 8'h00;
    bIn    = 8'h00;
    destIn = 2'd0;

    vecs[0]  = '{3'b000, 8'hF0, 8'h20, 2'd2, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{3'b001, 8'h05, 8'h05, 2'd1, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{3'b001, 8'h03, 8'h05, 2'd3, 8'hFE, 1'b1, 1'b0};
    vecs[3]  = '{3'b010, 8'hF0, 8'h3C, 2'd0, 8'h30, 1'b0, 1'b0};
    vecs[4]  = '{3'b011, 8'h0F, 8'h30, 2'd1, 8'h3F, 1'b0, 1'b0};
    vecs[5]  = '{3'b100, 8'hAA, 8'h55, 2'd2, 8'hFF, 1'b0, 1'b0};
    vecs[6]  = '{3'b101, 8'h40, 8'h00, 2'd3, 8'h80, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 8'h77, 8'h00, 2'd1, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{3'b000, 8'hFF, 8'h01, 2'd2, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{3'b110, 8'h0D, 8'h0B, 2'd1, 8'h8F, 1'b0, 1'b0};
    vecs[10] = '{3'b110, 8'h10, 8'h20, 2'd2, 8'h00, 1'b1, 1'b1};
    vecs[11] = '{3'b110, 8'hFF, 8'hFF, 2'd3, 8'h01, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_we", 16'(writeEnable), 16'd0);
    chk("rst_result", 16'(result), 16'd0);
    chk("rst_waddr", 16'(writeAddress), 16'd0);
    chk("rst_zero", 16'(zeroFlag), 16'd0);
    chk("rst_carry", 16'(carryFlag), 16'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      runOp(vecs[i], i);
    end

    // Async reset in MUL cycle 4 aborts the operation.
    issue(3'b110, 8'h0D, 8'h0B, 2'd2);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", 16'(busy), 16'd0);
    chk("ar_we", 16'(writeEnable), 16'd0);
    chk("ar_result", 16'(result), 16'd0);
    chk("ar_waddr", 16'(writeAddress), 16'd0);
    chk("ar_zero", 16'(zeroFlag), 16'd0);
    chk("ar_carry", 16'(carryFlag), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    weN = 0;
    repeat (12) begin
      @(negedge clk);
      if (writeEnable) weN++;
    end
    chk("ar_noWb", 16'(weN), 16'd0);
    v = '{3'b000, 8'h01, 8'h01, 2'd1, 8'h02, 1'b0, 1'b0};
    runOp(v, 20);

    // Starts during MUL are ignored; operands are latched.
    issue(3'b110, 8'h0D, 8'h0B, 2'd3);
    weN  = 0;
    weAt = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (writeEnable) begin
        weN++;
        weAt = c;
        chk("ct_result", 16'(result), 16'h8F);
        chk("ct_waddr", 16'(writeAddress), 16'd3);
      end
      if (c == 3 || c == 9) begin
        start  = 1'b1;
        op     = 3'b000;
        aIn    = 8'h01;
        bIn    = 8'h01;
        destIn = 2'd0;
      end else begin
        start = 1'b0;
      end
      if (c == 5) begin
        aIn = 8'hFF;
        bIn = 8'hFF;
      end
    end
    chk("ct_weCount", 16'(weN), 16'd1);
    chk("ct_weCycle", 16'(weAt), 16'd9);
    chk("ct_carry", 16'(carryFlag), 16'd0);
    chk("ct_hold", 16'(result), 16'h8F);
    chk("ct_idle", 16'(busy), 16'd0);

    // SHL, then XOR issued the cycle busy falls.
    issue(3'b101, 8'h81, 8'h00, 2'd1);
    we1 = -1;
    we2 = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (writeEnable) begin
        if (we1 < 0) begin
          we1 = c;
          chk("bb_res1", 16'(result), 16'h02);
          chk("bb_addr1", 16'(writeAddress), 16'd1);
        end else begin
          we2 = c;
          chk("bb_res2", 16'(result), 16'hF0);
          chk("bb_addr2", 16'(writeAddress), 16'd2);
        end
      end
      if (c == 2) begin
        chk("bb_busyLow", 16'(busy), 16'd0);
        chk("bb_carry1", 16'(carryFlag), 16'd1);
        start  = 1'b1;
        op     = 3'b100;
        aIn    = 8'hFF;
        bIn    = 8'h0F;
        destIn = 2'd2;
      end else begin
        start = 1'b0;
      end
      if (c == 4) begin
        chk("bb_carry2", 16'(carryFlag), 16'd0);
        chk("bb_zero2", 16'(zeroFlag), 16'd0);
      end
    end
    chk("bb_we1", 16'(we1), 16'd1);
    chk("bb_gap", 16'(we2 - we1), 16'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_execute_unit.md
# alu_execute_unit

Execute stage that consumes the two register-file read operands, performs an 8-bit ALU operation (single-cycle logic/arithmetic or an iterative 8-cycle shift-add multiply), and produces the write-back word, destination address and write enable that drive the register file's write port. Operands and destination are latched when a command is accepted, so register-file contents may change while an operation is in flight. Sits between the control sequencer (which issues `start`) and the register file write port.

## Interface
- No parameters. Data width is fixed at 8 bits and register address width at 2 bits.
- `clk` input 1: single clock. All state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: command valid. Accepted only when `busy` = 0.
- `op` input 3: opcode, sampled at acceptance.
- `aIn` input 8: operand A, from the register file A read port. Sampled at acceptance.
- `bIn` input 8: operand B, from the register file B read port. Sampled at acceptance.
- `destIn` input 2: destination register, sampled at acceptance.
- `busy` output 1: high in every state except IDLE.
- `result` output 8: write-back data, held until the next write-back.
- `writeAddress` output 2: destination for write-back.
- `writeEnable` output 1: one-cycle write strobe to the register file.
- `zeroFlag` output 1: result == 0 from the last write-back.
- `carryFlag` output 1: carry/borrow/overflow from the last write-back.

## Operation
- Opcodes:
  - 000 ADD: {carry,result} = a+b.
  - 001 SUB: result = a-b mod 256; carry = (a<b), i.e. borrow.
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 SHL: result = a<<1; carry = a[7].
  - 110 MUL: result = low byte of a*b; carry = (high byte != 0).
  - 111 MOVB: result = b; carry = 0.
- States and transitions:
  - IDLE: on `start`, latch op, A, B and dest. MUL goes to MUL; every other opcode computes its result into the working register and goes to WB.
  - MUL: unsigned shift-add with a 16-bit accumulator and a 3-bit iteration counter. Each cycle, if multiplier LSB = 1, add the shifted multiplicand. After 8 iterations (counter wraps 7→0), go to WB.
  - WB: `writeEnable` = 1, and `result`, `zeroFlag` and `carryFlag` update on the edge ending WB. Next state is IDLE.
- `start` while `busy` is ignored entirely: no latch, no queue.
- `writeEnable` is decoded from state WB. It does not depend combinationally on any input.
- Reset (any state, including mid-MUL): state IDLE; all outputs 0; no write-back is produced for the aborted operation.

## Timing
- Edge E0 accepts `start`.
- Single-cycle ops:
  - WB occupies the cycle after E0, with `writeEnable` high that cycle.
  - The register file captures the result at E2.
  - Throughput is one op per 2 cycles.
- MUL:
  - 8 MUL cycles follow E0, then WB, with `writeEnable` in cycle 9 after E0.
  - The register file captures at E10.
  - Throughput is one op per 10 cycles.
- `busy` is high from the cycle after acceptance through WB inclusive, and falls the cycle after WB.
- `result`/`writeAddress` are valid during the WB cycle and hold afterwards.
- The flags change only at write-back and hold otherwise.

## Structure
- Shared package `cpu_pkg`:
  - `op_t` enum, 3-bit, with the encodings above.
  - `exec_state_t` enum: IDLE, MUL, WB.
  - Constants `DATA_W = 8`, `REG_ADDR_W = 2`.
  - `cpu_pkg` is also used by the decoder/sequencer.
- One sub-module is natural: `shift_add_mul`, holding the accumulator and iteration counter, with start/done signalling to the top FSM. Single-cycle ops stay in the top module as a combinational case on `op_t`.

## Test plan
- ADD, a=0xF0, b=0x20, dest=2 -> `writeEnable` 1 cycle after accept; result 0x10, writeAddress 2, carry 1, zero 0.
- SUB, a=0x05, b=0x05 -> result 0x00, zero 1, carry 0. SUB a=0x03, b=0x05 -> result 0xFE, carry 1.
- MUL, a=0x0D, b=0x0B -> `busy` high 9 cycles; `writeEnable` exactly 9 cycles after accept; result 0x8F, carry 0. MUL a=0x10, b=0x20 -> result 0x00, zero 1, carry 1.
- Command contention:
  - Issue MUL, then pulse `start` with ADD on cycles 3 and 9 after accept -> both ignored; exactly one `writeEnable`, carrying the MUL result.
  - Change `aIn`/`bIn` during MUL -> result is unchanged.
- Assert `reset` asynchronously at MUL cycle 4 -> outputs 0 immediately; no `writeEnable` after release. A new ADD 1+1 then completes with result 0x02.
- Back-to-back: SHL a=0x81, then XOR a=0xFF, b=0x0F issued the cycle `busy` falls -> results 0x02 (carry 1) then 0xF0 (carry 0), with `writeEnable` pulses 2 cycles apart.
